// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an LSB-first UART serialiser with per-frame data/parity/stop format.
// Latency: push to tx falling edge is 2 clk. Backpressure: din_ready = !full from registered count.
module uart_tx_fifo #(
  parameter int OS_TICK    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_tick,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [1:0]                    cfg_dbits,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_odd,
  input  logic                          cfg_stop2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          tx_done_tick,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2 * OS_TICK);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OS_TICK - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef struct packed {
    logic [1:0] dbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } frame_cfg_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full, empty;

  logic [2:0]    state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  frame_cfg_t    cfg_q, cfg_n;
  logic          tx_n;
  logic          bit_end, stop_end;

  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign din_ready = !full;
  assign push      = din_valid && !full;
  assign pop       = (state == IDLE) && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din;
  end

  // The stop phase runs its counter past BIT_LAST when two stop bits are configured.
  assign bit_end      = s_tick && (tick_cnt == BIT_LAST);
  assign stop_end     = s_tick && (tick_cnt == (cfg_q.stop2 ? STOP2_LAST : BIT_LAST));
  assign tx_done_tick = (state == STOP) && stop_end;
  assign tx_busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par;
    cfg_n   = cfg_q;
    if (state != IDLE && s_tick) tick_n = tick_cnt + TW'(1);
    case (state)
      IDLE: if (pop) begin
        state_n = START;
        shift_n = fifo_mem[rd_ptr];
        cfg_n   = frame_cfg_t'({cfg_dbits, cfg_par_en, cfg_par_odd, cfg_stop2});
        tick_n  = '0;
        bit_n   = '0;
        par_n   = 1'b0;
      end
      START: if (bit_end) begin
        state_n = DATA;
        tick_n  = '0;
      end
      DATA: if (bit_end) begin
        tick_n  = '0;
        shift_n = {1'b0, shift[7:1]};
        par_n   = par ^ shift[0];
        if (bit_cnt == 3'd4 + {1'b0, cfg_q.dbits}) begin
          bit_n   = '0;
          state_n = cfg_q.par_en ? PARITY : STOP;
        end else begin
          bit_n = bit_cnt + 3'd1;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tick_n  = '0;
      end
      STOP: if (stop_end) begin
        state_n = IDLE;
        tick_n  = '0;
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n ^ cfg_n.par_odd;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      cfg_q    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      par      <= par_n;
      cfg_q    <= cfg_n;
      tx       <= tx_n;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO and per-frame runtime frame format (data bits, parity, stop bits). It accepts bytes over a valid/ready handshake, buffers them, and serialises them LSB-first at a bit rate set by an external oversampling tick from the shared baud-rate generator. It is the transmit half of the UART subsystem and the drop-in successor to the fixed-format transmitter.

## Interface
- `OS_TICK`, 16: `s_tick` pulses per bit period. Legal range 8..32.
- `FIFO_DEPTH`, 4: input FIFO entries. Must be a power of 2 and at least 2.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous reset, active-high.
- `s_tick` in 1: oversampling enable, one `clk` wide per pulse.
- `din` in 8: byte to send. Bits above the configured data width are ignored.
- `din_valid` in 1: producer has a byte on `din`.
- `din_ready` out 1: FIFO can accept a byte. Equal to `!full`, registered-state only.
- `cfg_dbits` in 2: data width. 00=5, 01=6, 10=7, 11=8.
- `cfg_par_en` in 1: append a parity bit.
- `cfg_par_odd` in 1: 1 selects odd parity, 0 selects even.
- `cfg_stop2` in 1: 1 selects two stop bits, 0 selects one.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `tx_busy` out 1: high whenever the state is not IDLE.
- `tx_done_tick` out 1: one-cycle pulse at the end of a frame's last stop bit.
- `tx` out 1: serial line, registered, idles high.

## Operation
- **FIFO**
  - A push occurs when `din_valid && din_ready`.
  - A pop occurs only in IDLE when the FIFO is not empty.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Data leaves in push order.
- **Configuration latch**
  - On a pop, `cfg_*` and the popped byte are captured into frame registers.
  - `cfg_*` changes during a frame take effect only on the next pop.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a pop. The shift register loads the byte, and the tick counter and bit counter clear.
  - START -> DATA after OS_TICK ticks.
  - DATA sends shift[0] for each bit. After OS_TICK ticks it shifts right and increments the bit counter. After the last configured bit it goes to PARITY if `par_en`, otherwise STOP.
  - PARITY -> STOP after OS_TICK ticks.
  - STOP lasts OS_TICK ticks, or 2*OS_TICK when `stop2`. On the last tick it pulses `tx_done_tick` and goes to IDLE.
- **Parity:** XOR of the transmitted data bits only, inverted when `par_odd`. It is accumulated during DATA.
- **Line levels:** `tx` = 1 in IDLE and STOP, 0 in START, the data bit in DATA, the parity bit in PARITY.
- **Tick counter:** $clog2(2*OS_TICK) bits wide. It counts only on `s_tick` and clears at every bit boundary.
- **Reset** (asynchronous, including mid-frame):
  - Frame logic: state IDLE; `tx`=1, `tx_busy`=0, `tx_done_tick`=0.
  - FIFO: emptied; `fifo_count`=0, `din_ready`=1.
  - Any partial frame is abandoned without a done pulse.

## Timing
- **Bit boundaries:** Each bit ends on the `clk` edge that samples its OS_TICK-th `s_tick`. `tx` changes on that same edge, since `tx` is registered from the next-state value.
- **Frame start:** `tx` falls on the edge where the state becomes START, i.e. the edge after the pop cycle.
- **Frame length:** a frame lasts (1 + dbits + par_en + 1 + stop2) * OS_TICK ticks.
- **Push-to-start latency:** with an empty FIFO and IDLE, a push in cycle N gives a pop in cycle N+1 and `tx`=0 from edge N+2.
- **Back-to-back frames:** `tx_done_tick` is high in the last STOP cycle. If the FIFO is non-empty, the next pop happens in the following (IDLE) cycle. So there is exactly one `clk` of idle between frames, with no extra bit time.
- **Handshake rules:**
  - `din_ready` does not depend combinationally on `din_valid`.
  - A full FIFO holds `din_ready` low until a pop; `din_ready` rises on the edge after the pop.
- **Tick edge cases:** `s_tick` high in IDLE has no effect. `s_tick` low stalls all counters.

## Test plan
- **8N1, 0x55:** `s_tick` every clk, cfg 11/0/0/0 -> `tx` = 0, then 1,0,1,0,1,0,1,0, then 1. Each bit is 16 clk. `tx_done_tick` fires exactly 160 ticks after START entry. `tx_busy` is high throughout.
- **7E1, 0xA3:** cfg 10/1/0/0 -> data bits 1,1,0,0,0,1,0 (bit7 not sent). Parity = 1. Frame is 160 ticks.
- **5O2, 0x1F:** cfg 00/1/1/1 -> data bits 1,1,1,1,1. Parity = 0. Stop high for 32 ticks. Frame is 144 ticks.
- **FIFO full:** `s_tick` held low, `din_valid` high with 0x01..0x06 on consecutive cycles.
  - 0x01 is popped; 0x02..0x05 are accepted. `din_ready` drops and `fifo_count`=4. 0x06 is held.
  - After ticks resume, frames go out in the order 01..05, each separated by one idle clk.
  - `din_ready` rises one clk after each pop.
- **Config change mid-frame:** set cfg_stop2=1 during the DATA bits of a frame -> the current frame keeps 1 stop bit. The next frame uses 2 stop bits.
- **Reset mid-DATA:** assert `reset` at the 3rd data bit -> `tx`=1, `tx_busy`=0, `fifo_count`=0 immediately. No `tx_done_tick`. After release, a new push gives a clean frame.
